// File: rtl/dm_byte_ctrl_if.sv
// Request/response bundle between the pipeline control unit and the
// data-memory controller.
interface dm_byte_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_byte_ctrl.sv
// Multi-cycle data-memory controller: word/byte loads and stores, byte stores
// done as read-modify-write, byte loads sign-extended.
module dm_byte_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    dm_byte_ctrl_if.slave bus
);
    localparam logic [1:0] OP_LW = 2'b00;
    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_LB = 2'b10;
    localparam logic [1:0] OP_SB = 2'b11;
    localparam int         DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            state_reg;
    logic [1:0]        op_reg;
    logic [ADDR_W+1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic              resp_err_reg;

    logic [31:0]       mem [0:DEPTH-1];
    logic [31:0]       rd_word;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       sb_word;
    logic [31:0]       wr_word;
    logic [7:0]        lane_byte;
    logic              accept;
    logic              req_misaligned;
    logic              mem_we;

    // Address bits above the word index are deliberately discarded (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    assign word_idx       = addr_reg[ADDR_W+1:2];
    assign lane           = addr_reg[1:0];
    assign accept         = bus.req_valid && req_ready_reg;
    assign req_misaligned = !bus.req_op[1] && (bus.req_addr[1:0] != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign sb_word[8*gi +: 8] = (lane == 2'(gi)) ? wdata_reg[7:0]
                                                          : rd_word[8*gi +: 8];
        end
    endgenerate

    assign wr_word   = (op_reg == OP_SW) ? wdata_reg : sb_word;
    assign lane_byte = rd_word[8*lane +: 8];
    assign mem_we    = (state_reg == S_WRITE) && !rst;

    // Control FSM; all handshake outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_LW;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    if (accept) begin
                        op_reg        <= bus.req_op;
                        addr_reg      <= bus.req_addr[ADDR_W+1:0];
                        wdata_reg     <= bus.req_wdata;
                        req_ready_reg <= 1'b0;
                        if (req_misaligned) begin
                            state_reg      <= S_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                        end else if (bus.req_op == OP_SW) begin
                            state_reg <= S_WRITE;
                        end else begin
                            state_reg <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (op_reg == OP_SB) begin
                        state_reg <= S_WRITE;
                    end else begin
                        state_reg      <= S_RESP;
                        resp_valid_reg <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_reg      <= S_RESP;
                    resp_valid_reg <= 1'b1;
                end
                S_RESP: begin
                    state_reg      <= S_IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    req_ready_reg  <= 1'b1;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Block RAM: contents survive reset; read port is registered into rd_word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_word;
        end
        if (state_reg == S_READ) begin
            rd_word <= mem[word_idx];
        end
    end

    // rd_word is the RAM output register, so load data is formatted from it
    // rather than re-registered, keeping the read latency at one READ cycle.
    always_comb begin
        bus.resp_rdata = 32'h0;
        if (resp_valid_reg && !resp_err_reg) begin
            if (op_reg == OP_LW) begin
                bus.resp_rdata = rd_word;
            end else if (op_reg == OP_LB) begin
                bus.resp_rdata = {{24{lane_byte[7]}}, lane_byte};
            end
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
endmodule

// File: tb/tb_dm_byte_ctrl.sv
// Scoreboard bench for dm_byte_ctrl: driver pushes expected responses, a
// forked monitor pops and compares data, error flag and latency.
module tb_dm_byte_ctrl;
    localparam logic [1:0] OP_LW = 2'b00;
    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_LB = 2'b10;
    localparam logic [1:0] OP_SB = 2'b11;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cnt;
    int   tests;
    int   fails;
    exp_t q[$];

    dm_byte_ctrl_if bus();

    dm_byte_ctrl #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", 32'(bus.req_ready), 32'd1);
                chk("rst_valid", 32'(bus.resp_valid), 32'd0);
                chk("rst_rdata", bus.resp_rdata, 32'h0);
                chk("rst_err", 32'(bus.resp_err), 32'd0);
            end else if (bus.resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    $display("[TB] resp rdata=%h err=%b lat=%0d (exp %h/%b/%0d)",
                             bus.resp_rdata, bus.resp_err, cnt - e.acc, e.rdata, e.err, e.lat);
                    chk("rdata", bus.resp_rdata, e.rdata);
                    chk("err", 32'(bus.resp_err), 32'(e.err));
                    chk("latency", 32'(cnt - e.acc), 32'(e.lat));
                end
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int el,
                         input bit keep, output int acc);
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("accept_timeout", 32'(guard), 32'd0);
        acc = cnt;
        q.push_back('{er, ee, el, cnt});
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            chk("resp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic op(input logic [1:0] o, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int el);
        int acc;
        $display("[TB] op=%0d addr=%h wdata=%h", o, addr, wd);
        issue(o, addr, wd, er, ee, el, 1'b0, acc);
        wait_done();
    endtask

    initial begin
        int a1;
        int a2;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Word store/load, byte read-modify-write and sign-extended byte loads
        op(OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        op(OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        op(OP_SB, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0, 3);
        op(OP_LW, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 2);
        op(OP_LB, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
        op(OP_LB, 32'h11, 32'h0, 32'h00000055, 1'b0, 2);
        op(OP_LB, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2);
        op(OP_LB, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0, 2);

        // Misaligned word ops
        op(OP_SW, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, 2);
        op(OP_SW, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        op(OP_LW, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 2);
        op(OP_LW, 32'h21, 32'h0, 32'h0, 1'b1, 1);

        // Address wrap and top byte lane
        op(OP_SW, 32'h1000, 32'h12345678, 32'h0, 1'b0, 2);
        op(OP_LW, 32'h0, 32'h0, 32'h12345678, 1'b0, 2);
        op(OP_SB, 32'h3, 32'h00000080, 32'h0, 1'b0, 3);
        op(OP_LW, 32'h0, 32'h0, 32'h80345678, 1'b0, 2);
        op(OP_LB, 32'h3, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        op(OP_LB, 32'h2, 32'h0, 32'h00000034, 1'b0, 2);

        // Second request held while busy: accepted only once IDLE returns
        $display("[TB] back-to-back LW 0x10 then LW 0x20");
        issue(OP_LW, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 2, 1'b1, a1);
        issue(OP_LW, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 2, 1'b0, a2);
        wait_done();
        chk("b2b_spacing", 32'(a2 - a1), 32'd3);

        // Reset during the WRITE of a byte store
        op(OP_SW, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
        $display("[TB] SB 0x31 interrupted by reset in WRITE");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SB;
        bus.req_addr  = 32'h31;
        bus.req_wdata = 32'h11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        // Request already present when reset releases
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h0;
        #1;
        rst = 1'b0;
        q.push_back('{32'hA5A5A5A5, 1'b0, 2, cnt});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_done();

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
